// File: rtl/alu_inst_sequencer.sv
// alu_inst_sequencer: clocked program runner for the ALU/register-file datapath.
// Holds up to 2**ADDR_W instructions, drives each on inst_out for SETTLE cycles,
// samples the ALU result/overflow at the end of each slot and reports it.
//
// Handshake: start is a request that is accepted only in IDLE (busy=0); done and
// res_valid are single-cycle pulses with no back-pressure, their data is valid in
// the same cycle as the pulse and holds until the next pulse.
module alu_inst_sequencer #(
    parameter int INST_W = 29,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int SETTLE = 4,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INST_W-1:0] prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              halt_on_ovf,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] alu_d_out,
    input  logic              alu_ovf,
    output logic [INST_W-1:0] inst_out,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ovf,
    output logic [ADDR_W-1:0] res_idx,
    output logic              ovf_sticky,
    output logic [1:0]        state_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(SETTLE) + 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [INST_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   len_q;
    logic              halt_q;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  cnt;

    logic              prog_wr;
    logic              accept_start;
    logic [ADDR_W:0]   start_len;
    logic [INST_W-1:0] first_inst;
    logic              slot_end;
    logic              ovf_halt;
    logic              last_inst;

    // A write in the same IDLE cycle as a start must be visible to the first issue.
    assign prog_wr      = prog_we && !busy;
    assign accept_start = (state == S_IDLE) && start;
    assign start_len    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign first_inst   = (prog_wr && (prog_addr == '0)) ? prog_data : mem[0];
    assign slot_end     = (state == S_RUN) && !abort && (cnt == CNT_LAST);
    assign ovf_halt     = slot_end && alu_ovf && halt_q;
    assign last_inst    = ({1'b0, pc} == (len_q - 1'b1));
    assign state_dbg    = state;

    // Program memory: not reset, written only while no run is in progress.
    always_ff @(posedge clk) begin
        if (prog_wr) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort wins over a capture in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (start_len == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (slot_end && (ovf_halt || last_inst)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: issue, settle counting, result capture and run status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_out   <= NOP_INST;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_idx    <= '0;
            ovf_sticky <= 1'b0;
            len_q      <= '0;
            halt_q     <= 1'b0;
            pc         <= '0;
            cnt        <= '0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        len_q      <= start_len;
                        halt_q     <= halt_on_ovf;
                        halted     <= 1'b0;
                        ovf_sticky <= 1'b0;
                        pc         <= '0;
                        cnt        <= '0;
                        if (start_len != '0) begin
                            inst_out <= first_inst;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy     <= 1'b0;
                        inst_out <= NOP_INST;
                        pc       <= '0;
                        cnt      <= '0;
                    end else if (slot_end) begin
                        res_data   <= alu_d_out;
                        res_ovf    <= alu_ovf;
                        res_idx    <= pc;
                        res_valid  <= 1'b1;
                        ovf_sticky <= ovf_sticky | alu_ovf;
                        if (ovf_halt) begin
                            halted <= 1'b1;
                        end else if (!last_inst) begin
                            pc       <= pc + 1'b1;
                            inst_out <= mem[pc + 1'b1];
                            cnt      <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    inst_out <= NOP_INST;
                end
                default: begin
                    busy     <= 1'b0;
                    inst_out <= NOP_INST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_inst_sequencer.sv
// tb_alu_inst_sequencer: drives programs through the sequencer against a small
// ALU/register-file environment and checks every reported result against a
// sequential reference execution of the same program.
module tb_alu_inst_sequencer;

    localparam int INST_W = 29;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int SETTLE = 4;
    localparam int DEPTH  = 32;
    localparam logic [INST_W-1:0] NOP = '0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              prog_we = 0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [INST_W-1:0] prog_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              halt_on_ovf = 0;
    logic              start = 0;
    logic              abort = 0;
    logic [DATA_W-1:0] alu_d_out;
    logic              alu_ovf;
    logic [INST_W-1:0] inst_out;
    logic              busy, done, halted, res_valid, res_ovf, ovf_sticky;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_idx;
    logic [1:0]        state_dbg;

    alu_inst_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .halt_on_ovf(halt_on_ovf),
        .start(start), .abort(abort), .alu_d_out(alu_d_out), .alu_ovf(alu_ovf),
        .inst_out(inst_out), .busy(busy), .done(done), .halted(halted),
        .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
        .res_idx(res_idx), .ovf_sticky(ovf_sticky), .state_dbg(state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int done_cnt = 0;
    int exp_cycles;
    logic exp_halted, exp_sticky;
    logic [ADDR_W+DATA_W:0] exp_q[$];
    logic [INST_W-1:0] prog_img [DEPTH];
    logic [DATA_W-1:0] env_regs [32];
    logic [DATA_W-1:0] obs_data [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction set of the environment ----------------
    // [28:26] op (1 add, 2 addi, else nop), [25:21] rd, [20:16] rs, [15:11] rt, [15:0] imm
    function automatic logic [INST_W-1:0] enc_add(input int rd, input int rs, input int rt);
        return {3'd1, 5'(rd), 5'(rs), 5'(rt), 11'd0};
    endfunction

    function automatic logic [INST_W-1:0] enc_addi(input int rd, input int rs, input int imm);
        return {3'd2, 5'(rd), 5'(rs), 16'(imm)};
    endfunction

    // Returns {signed overflow, sum}.
    function automatic logic [DATA_W:0] exec(input logic [INST_W-1:0] inst,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b_reg);
        logic [DATA_W-1:0] b, s;
        logic [DATA_W:0] r;
        r = '0;
        b = '0;
        if (inst[28:26] == 3'd1 || inst[28:26] == 3'd2) begin
            b = (inst[28:26] == 3'd1) ? b_reg : inst[15:0];
            s = a + b;
            r = {(a[15] == b[15]) && (s[15] != a[15]), s};
        end
        return r;
    endfunction

    // Combinational ALU fed from inst_out; its register file commits on each report.
    always_comb begin
        {alu_ovf, alu_d_out} = exec(inst_out, env_regs[inst_out[20:16]], env_regs[inst_out[15:11]]);
    end

    always @(negedge clk) begin
        if (res_valid && prog_img[res_idx][28:26] != 3'd0 && prog_img[res_idx][25:21] != 5'd0)
            env_regs[prog_img[res_idx][25:21]] = res_data;
    end

    // ---------------- reference model ----------------
    // Executes the program in order with its own registers; stops at the first
    // overflow when halting is requested.
    task automatic model_run(input int len_req, input bit halt);
        logic [DATA_W-1:0] m [32];
        logic [DATA_W:0] r;
        logic [INST_W-1:0] inst;
        int n, issued;
        for (int k = 0; k < 32; k++) m[k] = '0;
        n = (len_req > DEPTH) ? DEPTH : len_req;
        issued = 0;
        exp_halted = 0;
        exp_sticky = 0;
        for (int i = 0; i < n; i++) begin
            inst = prog_img[i];
            r = exec(inst, m[inst[20:16]], m[inst[15:11]]);
            if (inst[28:26] != 3'd0 && inst[25:21] != 5'd0) m[inst[25:21]] = r[15:0];
            exp_q.push_back({5'(i), r[16], r[15:0]});
            issued++;
            exp_sticky |= r[16];
            if (r[16] && halt) begin
                exp_halted = 1;
                break;
            end
        end
        exp_cycles = issued * SETTLE + 1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W:0] e;
        if (done) done_cnt++;
        if (!busy) check("idle_inst_nop", inst_out, NOP);
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL res_unexpected: got idx %0d data 0x%0h ovf %0b, none expected",
                         res_idx, res_data, res_ovf);
            end else begin
                e = exp_q.pop_front();
                check("res_idx_ovf_data", {res_idx, res_ovf, res_data}, e);
                obs_data[res_idx] = res_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prog_we = 1; prog_addr = 5'(i); prog_data = prog_img[i];
        end
        @(negedge clk);
        prog_we = 0;
    endtask

    task automatic start_run(input int len_req, input bit halt, input bit wr0,
                             input logic [INST_W-1:0] d0);
        @(negedge clk);
        if (wr0) begin
            prog_img[0] = d0;
            prog_we = 1; prog_addr = '0; prog_data = d0;
        end
        for (int r = 0; r < 32; r++) env_regs[r] = '0;
        model_run(len_req, halt);
        start = 1; prog_len = 6'(len_req); halt_on_ovf = halt;
        @(posedge clk); #1;
        start = 0; prog_we = 0;
        t_start = cyc;
    endtask

    task automatic wait_done(input string name);
        int waited = 0;
        while (!done && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_done_seen"}, done, 1);
        check({name, "_cycles"}, cyc - t_start, exp_cycles);
        check({name, "_halted"}, halted, exp_halted);
        check({name, "_sticky"}, ovf_sticky, exp_sticky);
        check({name, "_busy_off"}, busy, 0);
        check({name, "_all_results"}, exp_q.size(), 0);
    endtask

    task automatic sum_prog();
        prog_img[0] = enc_addi(1, 0, 0);
        prog_img[1] = enc_addi(2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            prog_img[2 + 2*k] = enc_add(1, 1, 2);
            prog_img[3 + 2*k] = enc_addi(2, 2, 1);
        end
    endtask

    task automatic rand_prog();
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 1) == 1)
                prog_img[i] = enc_add($urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else
                prog_img[i] = enc_addi($urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int dc;
        for (int i = 0; i < DEPTH; i++) prog_img[i] = '0;
        for (int r = 0; r < 32; r++) env_regs[r] = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_inst", inst_out, NOP);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_halted", halted, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_sticky", ovf_sticky, 0);

        // Sum program: 0+1+..+9 in R1, counter in R2.
        sum_prog();
        load_prog(22);
        start_run(22, 0, 0, '0);
        wait_done("sum");
        check("sum_idx20", obs_data[20], 16'h002D);
        check("sum_idx21", obs_data[21], 16'h000A);

        // Empty run.
        start_run(0, 0, 0, '0);
        wait_done("len0");

        // Overflow at idx2; mem[0] replaced by a write in the start cycle.
        prog_img[0] = enc_addi(1, 0, 1);
        prog_img[1] = enc_addi(2, 0, 1);
        prog_img[2] = enc_add(3, 1, 2);
        prog_img[3] = enc_addi(4, 0, 5);
        prog_img[4] = enc_add(5, 4, 4);
        load_prog(5);
        start_run(5, 1, 1, enc_addi(1, 0, 16'h7FFF));
        wait_done("ovf_halt");
        start_run(5, 0, 0, '0);
        wait_done("ovf_nohalt");

        // Abort at cycle 5: only idx0 reported, no done.
        sum_prog();
        load_prog(22);
        start_run(22, 0, 0, '0);
        repeat (4) begin @(posedge clk); #1; end
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_inst", inst_out, NOP);
        dc = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dc);
        check("abort_results", exp_q.size(), 21);
        exp_q.delete();
        abort = 1;
        repeat (2) @(posedge clk);
        #1;
        abort = 0;
        check("abort_idle_busy", busy, 0);
        start_run(22, 0, 0, '0);
        wait_done("after_abort");

        // Writes and start while busy are dropped.
        start_run(22, 0, 0, '0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        prog_we = 1; prog_addr = '0; prog_data = enc_addi(1, 0, 16'h1234); start = 1;
        @(negedge clk);
        prog_addr = 5'd3;
        @(negedge clk);
        prog_we = 0; start = 0;
        wait_done("busy_writes");
        start_run(22, 0, 0, '0);
        wait_done("rerun");

        // Reset mid-run, off the clock edge.
        rand_prog();
        load_prog(DEPTH);
        start_run(40, 0, 0, '0);
        repeat (10) @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("midrst_inst", inst_out, NOP);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_res_idx", res_idx, 0);
        check("midrst_res_ovf", res_ovf, 0);
        check("midrst_sticky", ovf_sticky, 0);
        exp_q.delete();
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst = 0;
        check("midrst_no_done", done_cnt, dc);

        // Length clamp and random runs.
        start_run(40, 0, 0, '0);
        wait_done("clamp40");
        for (int t = 0; t < 5; t++) begin
            rand_prog();
            load_prog(DEPTH);
            start_run($urandom_range(0, 40), 1'($urandom_range(0, 1)), 0, '0);
            wait_done("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
